// File: rtl/fpga_prog_pkg.sv
// Shared types and sizing helpers for the FPGA-side chip programming controller.
// Build option: FPGA_PROG_PARITY_EN appends one even-parity bit to every shifted word.
package fpga_prog_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRst,
    StShift,
    StWait,
    StDone,
    StError
  } prog_state_e;

  localparam int unsigned RetryW = 4;

`ifdef FPGA_PROG_PARITY_EN
  localparam int unsigned ParityBits = 1;
`else
  localparam int unsigned ParityBits = 0;
`endif

  // Number of bits clocked out per attempt.
  function automatic int unsigned num_bits(int unsigned cfg_w);
    return cfg_w + ParityBits;
  endfunction

  // Width of a counter that must hold values 0..max_val.
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fpga_prog_ctrl_if.sv
// Host-side control and chip-pin bundle of the programming controller.
// Build option: FPGA_PROG_PARITY_EN (no effect on the bundle itself).
interface fpga_prog_ctrl_if #(
  parameter int unsigned CFG_W = 5
);
  import fpga_prog_pkg::*;

  logic               i_start;
  logic [CFG_W-1:0]   i_cfg_word;
  logic               i_ready;
  logic               o_resetbAll;
  logic               o_sclk;
  logic               o_sdout;
  logic               o_busy;
  logic               o_done;
  logic               o_error;
  logic [RetryW-1:0]  o_retry_cnt;

  modport master (
    output i_start, i_cfg_word, i_ready,
    input  o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_error, o_retry_cnt
  );

  modport slave (
    input  i_start, i_cfg_word, i_ready,
    output o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_error, o_retry_cnt
  );

endinterface

// File: rtl/prog_sclk_div.sv
// Free-running divider emitting a one-cycle tick every 2**DIV_LOG2 enabled cycles.
// Build option: FPGA_PROG_PARITY_EN (not used here).
module prog_sclk_div #(
  parameter int unsigned DIV_LOG2 = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  logic [DIV_LOG2-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + DIV_LOG2'(1);
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == {DIV_LOG2{1'b1}});

endmodule

// File: rtl/fpga_prog_ctrl.sv
// Resets the chip, shifts a configuration word MSB-first over sclk/sdout, waits for ready, retries.
// Build option: FPGA_PROG_PARITY_EN sends an even-parity bit after the LSB.
module fpga_prog_ctrl
  import fpga_prog_pkg::*;
#(
  parameter int unsigned      CFG_W       = 5,
  parameter logic [CFG_W-1:0] CFG_DEFAULT = 5'b00100,
  parameter bit               AUTO_START  = 1'b1,
  parameter int unsigned      DIV_LOG2    = 4,
  parameter int unsigned      RST_CYC     = 4,
  parameter int unsigned      READY_TO    = 255,
  parameter int unsigned      MAX_RETRY   = 3
) (
  input  logic            i_mainclk,
  input  logic            i_resetbFPGA,
  fpga_prog_ctrl_if.slave bus
);

  localparam int unsigned Nb   = num_bits(CFG_W);
  localparam int unsigned BitW = cnt_width(Nb);
  localparam int unsigned RstW = cnt_width(RST_CYC);
  localparam int unsigned ToW  = cnt_width(READY_TO);

  prog_state_e       state_q, state_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [Nb-1:0]     sh_q, sh_d;
  logic [Nb-1:0]     tx_word;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              auto_pend_q, auto_pend_d;
  logic              rdy_meta_q, rdy_sync_q;
  logic              sclk_q, sclk_d;
  logic              sdout_q, sdout_d;
  logic              resetb_q, resetb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              div_tick;

`ifdef FPGA_PROG_PARITY_EN
  assign tx_word = {cfg_q, ^cfg_q};
`else
  assign tx_word = cfg_q;
`endif

  // Divider is held clear throughout RST so every SHIFT starts from a fresh half-period.
  prog_sclk_div #(
    .DIV_LOG2 (DIV_LOG2)
  ) u_sclk_div (
    .clk_i  (i_mainclk),
    .rst_ni (i_resetbFPGA),
    .en_i   (state_q == StShift),
    .clr_i  (state_q == StRst),
    .tick_o (div_tick)
  );

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    sh_d        = sh_q;
    rst_cnt_d   = rst_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    retry_d     = retry_q;
    auto_pend_d = auto_pend_q;
    sclk_d      = sclk_q;
    sdout_d     = sdout_q;

    case (state_q)
      StIdle, StDone, StError: begin
        sclk_d  = 1'b1;
        sdout_d = 1'b0;
        if (bus.i_start || auto_pend_q) begin
          state_d     = StRst;
          cfg_d       = auto_pend_q ? CFG_DEFAULT : bus.i_cfg_word;
          retry_d     = '0;
          rst_cnt_d   = '0;
          auto_pend_d = 1'b0;
        end
      end
      StRst: begin
        if (rst_cnt_q == RstW'(RST_CYC - 1)) begin
          state_d   = StShift;
          sh_d      = tx_word;
          bit_cnt_d = '0;
          sclk_d    = 1'b1;
          sdout_d   = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end
      StShift: begin
        if (div_tick) begin
          if (sclk_q) begin
            sclk_d  = 1'b0;
            sdout_d = sh_q[Nb-1];
            sh_d    = sh_q << 1;
          end else begin
            sclk_d = 1'b1;
            if (bit_cnt_q != BitW'(Nb)) begin
              bit_cnt_d = bit_cnt_q + BitW'(1);
            end
            if (bit_cnt_q == BitW'(Nb - 1)) begin
              state_d  = StWait;
              sdout_d  = 1'b0;
              to_cnt_d = '0;
            end
          end
        end
      end
      StWait: begin
        // Ready takes priority over a timeout landing on the same cycle.
        if (rdy_sync_q) begin
          state_d = StDone;
        end else if (to_cnt_q == ToW'(READY_TO)) begin
          if (retry_q < RetryW'(MAX_RETRY)) begin
            retry_d   = retry_q + RetryW'(1);
            rst_cnt_d = '0;
            state_d   = StRst;
          end else begin
            state_d = StError;
          end
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Status outputs follow the next state so they are registered yet cycle-aligned with it.
  assign resetb_d = (state_d != StRst);
  assign busy_d   = (state_d == StRst) || (state_d == StShift) || (state_d == StWait);
  assign done_d   = (state_d == StDone);
  assign error_d  = (state_d == StError);

  always_ff @(posedge i_mainclk or negedge i_resetbFPGA) begin
    if (!i_resetbFPGA) begin
      state_q     <= StIdle;
      cfg_q       <= '0;
      sh_q        <= '0;
      rst_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      retry_q     <= '0;
      auto_pend_q <= AUTO_START;
      rdy_meta_q  <= 1'b0;
      rdy_sync_q  <= 1'b0;
      sclk_q      <= 1'b1;
      sdout_q     <= 1'b0;
      resetb_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      sh_q        <= sh_d;
      rst_cnt_q   <= rst_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      retry_q     <= retry_d;
      auto_pend_q <= auto_pend_d;
      rdy_meta_q  <= bus.i_ready;
      rdy_sync_q  <= rdy_meta_q;
      sclk_q      <= sclk_d;
      sdout_q     <= sdout_d;
      resetb_q    <= resetb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.o_resetbAll = resetb_q;
  assign bus.o_sclk      = sclk_q;
  assign bus.o_sdout     = sdout_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_error     = error_q;
  assign bus.o_retry_cnt = retry_q;

endmodule

// File: tb/tb_fpga_prog_ctrl.sv
// Randomised bench for fpga_prog_ctrl: pin-level observer plus an attempt/bit-level reference model.
// Build option: FPGA_PROG_PARITY_EN changes the expected bit stream.
module tb_fpga_prog_ctrl;

  localparam int unsigned CFG_W     = 5;
  localparam int unsigned DIV_LOG2  = 4;
  localparam int unsigned RST_CYC   = 4;
  localparam int unsigned READY_TO  = 255;
  localparam int unsigned MAX_RETRY = 3;
  localparam logic [CFG_W-1:0] CFG_DEFAULT = 5'b00100;
`ifdef FPGA_PROG_PARITY_EN
  localparam int NB = CFG_W + 1;
`else
  localparam int NB = CFG_W;
`endif
  localparam int HALF = 1 << DIV_LOG2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpga_prog_ctrl_if #(.CFG_W(CFG_W)) pif ();

  fpga_prog_ctrl #(
    .CFG_W       (CFG_W),
    .CFG_DEFAULT (CFG_DEFAULT),
    .AUTO_START  (1'b1),
    .DIV_LOG2    (DIV_LOG2),
    .RST_CYC     (RST_CYC),
    .READY_TO    (READY_TO),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .i_mainclk    (clk),
    .i_resetbFPGA (rst_n),
    .bus          (pif)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Observer records, filled by observe() for one programming run.
  int   plen[$];
  int   pend_t[$];
  int   rise_t[$];
  bit   bits[$];
  int   stable_min;
  int   end_t;
  bit   timed_out;
  bit   fin_done;
  bit   fin_err;
  int   fin_retry;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_rstb"},  pif.o_resetbAll, 0);
    check_eq({tag, "_sclk"},  pif.o_sclk, 1);
    check_eq({tag, "_sdout"}, pif.o_sdout, 0);
    check_eq({tag, "_busy"},  pif.o_busy, 0);
    check_eq({tag, "_done"},  pif.o_done, 0);
    check_eq({tag, "_err"},   pif.o_error, 0);
    check_eq({tag, "_retry"}, pif.o_retry_cnt, 0);
  endtask

  task automatic start_run(input logic [CFG_W-1:0] w);
    @(negedge clk);
    pif.i_cfg_word = w;
    pif.i_start    = 1'b1;
    @(posedge clk);
    #1;
    pif.i_start    = 1'b0;
    pif.i_cfg_word = ~w;
    check_eq("start_busy",  pif.o_busy, 1);
    check_eq("start_rstb",  pif.o_resetbAll, 0);
    check_eq("start_err",   pif.o_error, 0);
    check_eq("start_done",  pif.o_done, 0);
    check_eq("start_retry", pif.o_retry_cnt, 0);
  endtask

  // Watch pins on falling edges until done/error. Chip ready appears once r reset pulses have ended.
  task automatic observe(input int r, input int poke_cyc, input logic [CFG_W-1:0] poke_word);
    int   low = 0;
    int   run = 0;
    logic p_sclk = 1'b1;
    logic p_sdout = 1'b0;
    plen.delete(); pend_t.delete(); rise_t.delete(); bits.delete();
    stable_min = 1 << 30;
    timed_out  = 1'b1;
    end_t      = 0;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      @(negedge clk);
      pif.i_start = (cyc == poke_cyc);
      if (cyc == poke_cyc) pif.i_cfg_word = poke_word;
      if (pif.o_sclk && !p_sclk) begin
        rise_t.push_back(cyc);
        bits.push_back(p_sdout);
        if (run < stable_min) stable_min = run;
      end
      run     = (pif.o_sdout == p_sdout) ? run + 1 : 1;
      p_sclk  = pif.o_sclk;
      p_sdout = pif.o_sdout;
      if (!pif.o_resetbAll) begin
        low++;
      end else if (low > 0) begin
        plen.push_back(low);
        pend_t.push_back(cyc);
        low = 0;
      end
      pif.i_ready = (plen.size() >= r);
      if (pif.o_done || pif.o_error) begin
        timed_out = 1'b0;
        end_t     = cyc;
        fin_done  = pif.o_done;
        fin_err   = pif.o_error;
        fin_retry = int'(pif.o_retry_cnt);
        break;
      end
    end
  endtask

  // Reference: ready during attempt r (r<=1 means the first) finishes that attempt; beyond the
  // retry budget the run ends in error after MAX_RETRY+1 attempts.
  task automatic check_run(input logic [CFG_W-1:0] w, input int r);
    int          att;
    bit          exp_err;
    logic [NB-1:0] tx;
    int          k;
    int          gap;
`ifdef FPGA_PROG_PARITY_EN
    tx = {w, ^w};
`else
    tx = w;
`endif
    att     = (r <= 1) ? 1 : r;
    exp_err = (att > int'(MAX_RETRY) + 1);
    if (exp_err) att = MAX_RETRY + 1;
    check_eq("run_end", timed_out, 0);
    check_eq("attempts", plen.size(), att);
    foreach (plen[i]) check_eq("rst_len", plen[i], RST_CYC);
    check_eq("nbits", bits.size(), att * NB);
    if (bits.size() == att * NB && pend_t.size() == att) begin
      for (int a = 0; a < att; a++) begin
        for (int i = 0; i < NB; i++) begin
          k = a * NB + i;
          check_eq("bit", bits[k], tx[NB-1-i]);
          check_eq("rise_gap", rise_t[k] - ((i == 0) ? pend_t[a] : rise_t[k-1]), 2 * HALF);
        end
        if (a < att - 1) begin
          gap = (pend_t[a+1] - plen[a+1]) - rise_t[a*NB+NB-1];
          check_eq("wait_len", (gap >= int'(READY_TO) && gap <= int'(READY_TO) + 4), 1);
        end
      end
      gap = end_t - rise_t[att*NB-1];
      if (exp_err) check_eq("err_wait", (gap >= int'(READY_TO) && gap <= int'(READY_TO) + 4), 1);
      else         check_eq("done_lat", (gap >= 1 && gap <= 3), 1);
    end
    check_eq("done",  fin_done, !exp_err);
    check_eq("error", fin_err, exp_err);
    check_eq("retry", fin_retry, exp_err ? int'(MAX_RETRY) : att - 1);
    check_eq("sd_stable", (stable_min >= HALF), 1);
  endtask

  initial begin
    logic [CFG_W-1:0] w;
    int r;
    int n;
    logic p;

    pif.i_start    = 1'b0;
    pif.i_cfg_word = '0;
    pif.i_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("por");

    // Auto-start after reset release sends the default word.
    @(negedge clk);
    rst_n = 1'b1;
    observe(0, 0, '0);
    check_run(CFG_DEFAULT, 0);

    // Explicit start from DONE.
    start_run(5'b10110);
    observe(0, 0, '0);
    check_run(5'b10110, 0);

    // Chip never ready: full retry budget then error; next start clears it.
    w = CFG_W'($urandom);
    start_run(w);
    observe(99, 0, '0);
    check_run(w, 99);
    w = CFG_W'($urandom);
    start_run(w);
    observe(0, 0, '0);
    check_run(w, 0);

    // Ready shows up during the second attempt.
    w = CFG_W'($urandom);
    start_run(w);
    observe(2, 0, '0);
    check_run(w, 2);

    // Asynchronous reset while bit 3 is on the wire.
    start_run(5'b10110);
    n = 0;
    p = 1'b1;
    for (int c = 0; c < 2000 && n < 3; c++) begin
      @(negedge clk);
      if (pif.o_sclk && !p) n++;
      p = pif.o_sclk;
    end
    check_eq("mid_reach", n, 3);
    repeat (20) @(negedge clk);
    check_eq("mid_sdout_pre", pif.o_sdout, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outs("mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    observe(0, 0, '0);
    check_run(CFG_DEFAULT, 0);

    // A start while busy must be ignored.
    start_run(5'b10110);
    observe(0, 100, 5'b01001);
    check_run(5'b10110, 0);
    repeat (40) @(negedge clk);
    check_eq("busy_start_ign_busy", pif.o_busy, 0);
    check_eq("busy_start_ign_done", pif.o_done, 1);

    for (int it = 0; it < 5; it++) begin
      w = CFG_W'($urandom);
      r = $urandom_range(0, 5);
      start_run(w);
      observe(r, 0, '0);
      check_run(w, r);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
